// File: rtl/mandelbrot_pixel_out.sv
// +----------------------------------------------------------------------------+
// | mandelbrot_pixel_out: launches one engine computation at a time, tags each |
// | result with frame position and queues it in a small output FIFO.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mandelbrot_pixel_out #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       engine_running,
  input  logic [3:0]                 engine_ctr,
  output logic                       engine_run,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [3:0]                 pix_data,
  output logic                       pix_sof,
  output logic                       pix_eol,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [LW-1:0] c_DEPTH   = LW'(DEPTH);
  localparam logic [XW-1:0] c_PX_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] c_PY_LAST = YW'(HEIGHT - 1);

  localparam logic [1:0] c_IDLE       = 2'd0;
  localparam logic [1:0] c_LAUNCH     = 2'd1;
  localparam logic [1:0] c_WAIT_START = 2'd2;
  localparam logic [1:0] c_WAIT_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] px_q, px_d;
  logic [YW-1:0] py_q, py_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [5:0]    mem_q [DEPTH];

  logic       w_launch;
  logic       w_push;
  logic       w_pop;
  logic       w_sof;
  logic       w_eol;
  logic [5:0] w_head;

  always_comb begin
    state_d  = state_q;
    w_launch = 1'b0;
    w_push   = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (enable) state_d = c_LAUNCH;
      end
      c_LAUNCH: begin
        if ((level_q != c_DEPTH) && !engine_running) begin
          w_launch = 1'b1;
          state_d  = c_WAIT_START;
        end else if (!enable) begin
          state_d = c_IDLE;
        end
      end
      c_WAIT_START: begin
        if (engine_running) state_d = c_WAIT_DONE;
      end
      c_WAIT_DONE: begin
        // Capture regardless of enable so an in-flight pixel is never lost.
        if (!engine_running) begin
          w_push  = 1'b1;
          state_d = enable ? c_LAUNCH : c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  assign engine_run = w_launch & rst_n;
  assign w_pop      = (level_q != '0) & pix_ready;
  assign w_sof      = (px_q == '0) && (py_q == '0);
  assign w_eol      = (px_q == c_PX_LAST);

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (w_push) begin
      if (px_q == c_PX_LAST) begin
        px_d = '0;
        py_d = (py_q == c_PY_LAST) ? '0 : py_q + YW'(1);
      end else begin
        px_d = px_q + XW'(1);
      end
    end
  end

  always_comb begin
    level_d = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= c_IDLE;
      px_q     <= '0;
      py_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      level_q <= level_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage is left unreset; the output mux hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= {w_sof, w_eol, engine_ctr};
  end

  assign w_head     = mem_q[rd_ptr_q];
  assign pix_valid  = (level_q != '0);
  assign pix_data   = pix_valid ? w_head[3:0] : 4'd0;
  assign pix_eol    = pix_valid & w_head[4];
  assign pix_sof    = pix_valid & w_head[5];
  assign fifo_level = level_q;

endmodule

`default_nettype wire
